// File: rtl/dmem_arbiter_pkg.sv
// Shared control definitions for the data-memory path.
// Holds the memory command encodings (memnop/memwld/memwst) used by both
// dmem_arbiter and data_mem, plus the arbiter FSM state encodings.
package dmem_arbiter_pkg;

  // Memory command encodings on dm_ctrl_sig
  localparam logic [1:0] MEMNOP = 2'b00;
  localparam logic [1:0] MEMWLD = 2'b01;
  localparam logic [1:0] MEMWST = 2'b10;

  // Arbiter FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_CAPT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Memory command for a latched access direction
  function automatic logic [1:0] mem_op(input logic we);
    return we ? MEMWST : MEMWLD;
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way grant picker.
// Ports:
//   valid_i [1:0] : request valids, bit p = requester p
//   ptr_i         : preferred port when both request
//   gnt_o   [1:0] : one-hot (or zero) grant
module dmem_rr_pick
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = valid_i;
    // Only a conflict consults the pointer; a lone requester always wins.
    if (&valid_i) gnt_o = ptr_i ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-ported data memory.
// One transaction in flight: IDLE (grant) -> ISSUE (memory command) ->
// CAPT (loads only, capture read data) -> RESP (hold until rsp_ready).
// Out-of-range addresses skip the memory access and answer with rsp_err.
//
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration on conflict;
// without it port 0 has fixed priority and no pointer register exists.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   req{0,1}_valid/we/addr/wdata : requester inputs
//   req{0,1}_gnt         : one-cycle acceptance pulse
//   rsp_valid/port/rdata/err, rsp_ready : response handshake
//   dm_ctrl_sig, mem_ctrl_addr, dm_data_in : memory command outputs
//   dm_data_out          : registered memory read data
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 128,
  parameter int MEM_DEPTH = 256
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_gnt,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_gnt,
  output logic              rsp_valid,
  output logic              rsp_port,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              rsp_ready,
  output logic [1:0]        dm_ctrl_sig,
  output logic [ADDR_W-1:0] mem_ctrl_addr,
  output logic [DATA_W-1:0] dm_data_in,
  input  logic [DATA_W-1:0] dm_data_out
);

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              port_q, port_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0]        pick_gnt;
  logic [1:0]        gnt_w;
  logic              grant_en;
  logic              ptr;
  logic              sel_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              issue_act;

`ifdef DMEM_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Pointer names the port preferred on the next conflict: the one not
  // granted last. It only moves when a grant is actually issued.
  always_comb begin
    ptr_d = ptr_q;
    if (|gnt_w) ptr_d = gnt_w[0];
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  dmem_rr_pick u_pick (
    .valid_i ({req1_valid, req0_valid}),
    .ptr_i   (ptr),
    .gnt_o   (pick_gnt)
  );

  // Grants only in IDLE and never while reset is held, so nothing is
  // accepted that the reset edge would immediately discard.
  assign grant_en = (state_q == ST_IDLE) && !reset;
  assign gnt_w    = pick_gnt & {2{grant_en}};
  assign req0_gnt = gnt_w[0];
  assign req1_gnt = gnt_w[1];

  assign sel_port  = gnt_w[1];
  assign sel_we    = sel_port ? req1_we    : req0_we;
  assign sel_addr  = sel_port ? req1_addr  : req0_addr;
  assign sel_wdata = sel_port ? req1_wdata : req0_wdata;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    port_d  = port_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt_w) begin
          state_d = ST_ISSUE;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          port_d  = sel_port;
          err_d   = (sel_addr >= ADDR_W'(MEM_DEPTH));
        end
      end
      ST_ISSUE: begin
        // Clear read data here so stores and errors answer with zero.
        rdata_d = '0;
        state_d = (we_q || err_q) ? ST_RESP : ST_CAPT;
      end
      ST_CAPT: begin
        rdata_d = dm_data_out;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      port_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      port_q  <= port_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory command decodes straight from the current state, so a store
  // sitting in ISSUE still reaches memory on the edge that applies reset.
  assign issue_act     = (state_q == ST_ISSUE) && !err_q;
  assign dm_ctrl_sig   = issue_act ? mem_op(we_q) : MEMNOP;
  assign mem_ctrl_addr = issue_act ? addr_q  : '0;
  assign dm_data_in    = issue_act ? wdata_q : '0;

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_port  = port_q;
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_we, req0_gnt;
  logic [31:0]  req0_addr;
  logic [127:0] req0_wdata;
  logic         req1_valid, req1_we, req1_gnt;
  logic [31:0]  req1_addr;
  logic [127:0] req1_wdata;
  logic         rsp_valid, rsp_port, rsp_err, rsp_ready;
  logic [127:0] rsp_rdata;
  logic [1:0]   dm_ctrl_sig;
  logic [31:0]  mem_ctrl_addr;
  logic [127:0] dm_data_in, dm_data_out;

  logic [127:0] mem [0:255];
  logic         pre_en;
  logic [7:0]   pre_addr;
  logic [127:0] pre_data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // Data memory model: registered read, write on memwst
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (dm_ctrl_sig == MEMWST) mem[mem_ctrl_addr[7:0]] <= dm_data_in;
    if (dm_ctrl_sig == MEMWLD) dm_data_out <= mem[mem_ctrl_addr[7:0]];
  end

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_gnt(req0_gnt),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_gnt(req1_gnt),
    .rsp_valid(rsp_valid), .rsp_port(rsp_port), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .dm_ctrl_sig(dm_ctrl_sig), .mem_ctrl_addr(mem_ctrl_addr),
    .dm_data_in(dm_data_in), .dm_data_out(dm_data_out)
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    pre_en = 1'b1; pre_addr = 8'd5; pre_data = 128'hA5;
    next_cycle();
    pre_en = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    total_cnt++; if (req0_gnt !== 1'b0) $display("FAIL rst_gnt0 got=%b exp=0", req0_gnt); else pass_cnt++;
    total_cnt++; if (req1_gnt !== 1'b0) $display("FAIL rst_gnt1 got=%b exp=0", req1_gnt); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_port !== 1'b0) $display("FAIL rst_rsp_port got=%b exp=0", rsp_port); else pass_cnt++;
    total_cnt++; if (rsp_err !== 1'b0) $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); else pass_cnt++;
    total_cnt++; if (rsp_rdata !== 128'h0) $display("FAIL rst_rdata got=%h exp=0", rsp_rdata); else pass_cnt++;
    total_cnt++; if (dm_ctrl_sig !== MEMNOP) $display("FAIL rst_ctrl got=%b exp=%b", dm_ctrl_sig, MEMNOP); else pass_cnt++;
    total_cnt++; if (mem_ctrl_addr !== 32'h0) $display("FAIL rst_addr got=%h exp=0", mem_ctrl_addr); else pass_cnt++;
    total_cnt++; if (dm_data_in !== 128'h0) $display("FAIL rst_din got=%h exp=0", dm_data_in); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_load;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'd5;
    @(negedge clk);
    total_cnt++; if (req0_gnt !== 1'b1) $display("FAIL ld_gnt0 got=%b exp=1", req0_gnt); else pass_cnt++;
    total_cnt++; if (req1_gnt !== 1'b0) $display("FAIL ld_gnt1 got=%b exp=0", req1_gnt); else pass_cnt++;
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (dm_ctrl_sig !== MEMWLD) $display("FAIL ld_ctrl got=%b exp=%b", dm_ctrl_sig, MEMWLD); else pass_cnt++;
    total_cnt++; if (mem_ctrl_addr !== 32'd5) $display("FAIL ld_addr got=%0d exp=5", mem_ctrl_addr); else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL ld_early_vld got=%b exp=0", rsp_valid); else pass_cnt++;
    total_cnt++; if (dm_ctrl_sig !== MEMNOP) $display("FAIL ld_capt_ctrl got=%b exp=%b", dm_ctrl_sig, MEMNOP); else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL ld_vld got=%b exp=1", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_rdata !== 128'hA5) $display("FAIL ld_rdata got=%h exp=a5", rsp_rdata); else pass_cnt++;
    total_cnt++; if (rsp_port !== 1'b0) $display("FAIL ld_port got=%b exp=0", rsp_port); else pass_cnt++;
    total_cnt++; if (rsp_err !== 1'b0) $display("FAIL ld_err got=%b exp=0", rsp_err); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_store_then_load;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'd9; req1_wdata = 128'h1234;
    @(negedge clk);
    total_cnt++; if (req1_gnt !== 1'b1) $display("FAIL st_gnt1 got=%b exp=1", req1_gnt); else pass_cnt++;
    total_cnt++; if (req0_gnt !== 1'b0) $display("FAIL st_gnt0 got=%b exp=0", req0_gnt); else pass_cnt++;
    next_cycle();
    req1_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (dm_ctrl_sig !== MEMWST) $display("FAIL st_ctrl got=%b exp=%b", dm_ctrl_sig, MEMWST); else pass_cnt++;
    total_cnt++; if (mem_ctrl_addr !== 32'd9) $display("FAIL st_addr got=%0d exp=9", mem_ctrl_addr); else pass_cnt++;
    total_cnt++; if (dm_data_in !== 128'h1234) $display("FAIL st_din got=%h exp=1234", dm_data_in); else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL st_vld got=%b exp=1", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_port !== 1'b1) $display("FAIL st_port got=%b exp=1", rsp_port); else pass_cnt++;
    total_cnt++; if (rsp_rdata !== 128'h0) $display("FAIL st_rdata got=%h exp=0", rsp_rdata); else pass_cnt++;
    next_cycle();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'd9;
    @(negedge clk);
    total_cnt++; if (req0_gnt !== 1'b1) $display("FAIL stld_gnt0 got=%b exp=1", req0_gnt); else pass_cnt++;
    next_cycle();
    req0_valid = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL stld_vld got=%b exp=1", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_rdata !== 128'h1234) $display("FAIL stld_rdata got=%h exp=1234", rsp_rdata); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_out_of_range;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'd256;
    @(negedge clk);
    total_cnt++; if (req0_gnt !== 1'b1) $display("FAIL oob_gnt0 got=%b exp=1", req0_gnt); else pass_cnt++;
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (dm_ctrl_sig !== MEMNOP) $display("FAIL oob_issue_ctrl got=%b exp=%b", dm_ctrl_sig, MEMNOP); else pass_cnt++;
    total_cnt++; if (mem_ctrl_addr !== 32'h0) $display("FAIL oob_issue_addr got=%h exp=0", mem_ctrl_addr); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL oob_early_vld got=%b exp=0", rsp_valid); else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++; if (dm_ctrl_sig !== MEMNOP) $display("FAIL oob_resp_ctrl got=%b exp=%b", dm_ctrl_sig, MEMNOP); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL oob_vld got=%b exp=1", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_err !== 1'b1) $display("FAIL oob_err got=%b exp=1", rsp_err); else pass_cnt++;
    total_cnt++; if (rsp_rdata !== 128'h0) $display("FAIL oob_rdata got=%h exp=0", rsp_rdata); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'd5;
    @(negedge clk);
    total_cnt++; if (req1_gnt !== 1'b1) $display("FAIL bp_gnt1 got=%b exp=1", req1_gnt); else pass_cnt++;
    next_cycle();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'd9;
    @(negedge clk);
    total_cnt++; if (req0_gnt !== 1'b0) $display("FAIL bp_busy_gnt0 got=%b exp=0", req0_gnt); else pass_cnt++;
    next_cycle();
    next_cycle();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL bp_hold_vld c=%0d got=%b exp=1", c, rsp_valid); else pass_cnt++;
      total_cnt++; if (rsp_rdata !== 128'hA5) $display("FAIL bp_hold_rdata c=%0d got=%h exp=a5", c, rsp_rdata); else pass_cnt++;
      total_cnt++; if (rsp_port !== 1'b1) $display("FAIL bp_hold_port c=%0d got=%b exp=1", c, rsp_port); else pass_cnt++;
      total_cnt++; if (req0_gnt !== 1'b0) $display("FAIL bp_hold_gnt0 c=%0d got=%b exp=0", c, req0_gnt); else pass_cnt++;
      next_cycle();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL bp_rel_vld got=%b exp=1", rsp_valid); else pass_cnt++;
    total_cnt++; if (req0_gnt !== 1'b0) $display("FAIL bp_rel_gnt0 got=%b exp=0", req0_gnt); else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++; if (req0_gnt !== 1'b1) $display("FAIL bp_next_gnt0 got=%b exp=1", req0_gnt); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL bp_idle_vld got=%b exp=0", rsp_valid); else pass_cnt++;
    next_cycle();
    req0_valid = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    total_cnt++; if (rsp_rdata !== 128'h1234) $display("FAIL bp_next_rdata got=%h exp=1234", rsp_rdata); else pass_cnt++;
    total_cnt++; if (rsp_port !== 1'b0) $display("FAIL bp_next_port got=%b exp=0", rsp_port); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_reset_in_capt;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'd5;
    @(negedge clk);
    total_cnt++; if (req0_gnt !== 1'b1) $display("FAIL rc_gnt0 got=%b exp=1", req0_gnt); else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++; if (req0_gnt !== 1'b0) $display("FAIL rc_issue_gnt0 got=%b exp=0", req0_gnt); else pass_cnt++;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rc_vld got=%b exp=0", rsp_valid); else pass_cnt++;
    total_cnt++; if (dm_ctrl_sig !== MEMNOP) $display("FAIL rc_ctrl got=%b exp=%b", dm_ctrl_sig, MEMNOP); else pass_cnt++;
    total_cnt++; if (rsp_rdata !== 128'h0) $display("FAIL rc_rdata got=%h exp=0", rsp_rdata); else pass_cnt++;
    total_cnt++; if (req0_gnt !== 1'b1) $display("FAIL rc_regrant got=%b exp=1", req0_gnt); else pass_cnt++;
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (dm_ctrl_sig !== MEMWLD) $display("FAIL rc_reissue got=%b exp=%b", dm_ctrl_sig, MEMWLD); else pass_cnt++;
    next_cycle();
    next_cycle();
    @(negedge clk);
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL rc_final_vld got=%b exp=1", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_rdata !== 128'hA5) $display("FAIL rc_final_rdata got=%h exp=a5", rsp_rdata); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_back_to_back;
    logic order [0:3];
    int   n;
    logic exp_port;
    n = 0;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'd5;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'd9;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (req0_gnt || req1_gnt) begin
        total_cnt++;
        if (req0_gnt && req1_gnt) $display("FAIL b2b_onehot got=11 exp=one_hot"); else pass_cnt++;
        order[n] = req1_gnt;
        n++;
      end
      next_cycle();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    total_cnt++; if (n != 4) $display("FAIL b2b_count got=%0d exp=4", n); else pass_cnt++;
    for (int i = 0; i < 4 && i < n; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp_port = i[0];
`else
      exp_port = 1'b0;
`endif
      total_cnt++;
      if (order[i] !== exp_port) $display("FAIL b2b_order i=%0d got=%b exp=%b", i, order[i], exp_port); else pass_cnt++;
    end
    repeat (4) next_cycle();
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    #1;
    test_reset();
    test_load();
    test_store_then_load();
    test_out_of_range();
    test_backpressure();
    test_reset_in_capt();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=no_finish exp=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL take parameters: ADDR_W, 32, address width; DATA_W, 128, data word width; MEM_DEPTH, 256, number of valid memory words.
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on posedge; reset  in  1  synchronous, active-high.
REQ-003 SHALL have requester ports, p in {0,1}: reqp_valid  in  1  request; reqp_we  in  1  1=store, 0=load; reqp_addr  in  [0:31]  word address; reqp_wdata  in  [0:127]  store data; reqp_gnt  out  1  one-cycle acceptance pulse.
REQ-004 SHALL have response ports: rsp_valid  out  1; rsp_port  out  1  granted requester; rsp_rdata  out  [0:127]; rsp_err  out  1  address out of range; rsp_ready  in  1.
REQ-005 SHALL have memory ports: dm_ctrl_sig  out  [0:1]  memwld/memwst/memnop; mem_ctrl_addr  out  [0:31]; dm_data_in  out  [0:127]; dm_data_out  in  [0:127]  registered memory read data.

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, CAPT, RESP; one transaction in flight at most.
REQ-007 IDLE: if any reqp_valid, SHALL select one requester, pulse its reqp_gnt that cycle, latch we/addr/wdata/port, go to ISSUE; otherwise stay in IDLE.
REQ-008 ISSUE: SHALL drive dm_ctrl_sig=memwld (load) or memwst (store), latched address and data, for exactly one cycle; all other cycles SHALL drive memnop with mem_ctrl_addr and dm_data_in held at 0.
REQ-009 ISSUE exit: a load SHALL go to CAPT; a store SHALL go to RESP.
REQ-010 CAPT: SHALL register dm_data_out into rsp_rdata, then go to RESP.
REQ-011 RESP: rsp_valid SHALL be 1 with rsp_port, rsp_rdata, rsp_err stable until the cycle rsp_ready=1; the FSM SHALL then return to IDLE. A store SHALL return rsp_rdata=0.
REQ-012 Latency: with request accepted in cycle N, rsp_valid SHALL first assert in cycle N+3 for a load and N+2 for a store.
REQ-013 Address >= MEM_DEPTH: SHALL go IDLE->ISSUE->RESP with memnop in ISSUE (no memory access), rsp_err=1, rsp_rdata=0.
REQ-014 Requests arriving while not in IDLE SHALL be held off (no gnt); requesters keep valid asserted until gnt.
REQ-015 Simultaneous valid on both ports SHALL be resolved per the Configuration section; a single valid requester SHALL always be granted.
REQ-016 At most one reqp_gnt SHALL be high in any cycle.

Reset
REQ-017 On reset=1 at a clk edge, SHALL enter IDLE, abandoning any in-flight transaction without a response.
REQ-018 After reset, gnt and rsp_valid SHALL be 0, rsp_port, rsp_err, and rsp_rdata SHALL be 0, and the memory port SHALL be memnop with address and data 0.
REQ-019 Under reset, the round-robin pointer SHALL point to port 0.
REQ-020 A store in ISSUE when reset asserts SHALL still reach memory that edge; no guarantee beyond.

Configuration
REQ-021 With DMEM_ARB_RR_EN defined, SHALL use round-robin arbitration: on conflict, grant the port not granted last; the pointer updates only on a grant.
REQ-022 Without DMEM_ARB_RR_EN, SHALL use fixed priority: port 0 always wins a conflict, and no pointer register exists.

Structure
REQ-023 The memwld/memwst/memnop encodings and FSM state encodings SHALL live in the shared control definitions package, which is also used by data_mem.
REQ-024 Arbitration SHALL be a sub-module dmem_rr_pick (valid[0:1], pointer -> one-hot grant).

Verification
REQ-025 Port-0 load from addr 5 (memory preloaded with 128'hA5), rsp_ready=1 -> gnt0 at N, memwld with addr 5 at N+1, rsp_valid at N+3 with rsp_rdata=128'hA5 and rsp_port=0.
REQ-026 Port-1 store of 128'h1234 to addr 9, then port-0 load of addr 9 -> store rsp_valid at N+2; load returns 128'h1234.
REQ-027 Both ports continuously valid for four transactions -> with DMEM_ARB_RR_EN, gnt order is 0,1,0,1; without it, gnt order is 0,0,0,0.
REQ-028 Load addr 256 -> dm_ctrl_sig stays memnop throughout, rsp_err=1, rsp_rdata=0.
REQ-029 rsp_ready held 0 for 5 cycles during RESP -> rsp_valid and all response data stable, no new gnt; after rsp_ready=1, the next gnt follows one cycle later.
REQ-030 reset asserted in CAPT -> next cycle IDLE, rsp_valid=0, memnop; the pending request is re-granted.
